// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: stage-state encoding, default widths and MEM->WB payload layout.
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stageState_t;

  localparam int unsigned DATA_W_DEFAULT  = 32;
  localparam int unsigned RADDR_W_DEFAULT = 5;

  // Field order of the MEM->WB payload, MSB first, shown at default widths.
  typedef struct packed {
    logic                       regWrite;
    logic                       memToReg;
    logic [DATA_W_DEFAULT-1:0]  memData;
    logic [DATA_W_DEFAULT-1:0]  aluResult;
    logic [RADDR_W_DEFAULT-1:0] rd;
    logic                       side;
  } memWbPayload_t;

  function automatic int unsigned payloadWidth(int unsigned dataW, int unsigned raddrW,
                                               int unsigned sideW);
    return 2 + 2 * dataW + raddrW + sideW;
  endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// Enable-loaded payload register with asynchronous reset to zero.
module pipe_payload_reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_wb_pipe_stage.sv
// MEM->WB pipeline stage with valid/ready handshake and 2-entry skid buffer.
// Optional stall_cnt output enabled by defining MEM_WB_STALL_CNT_EN.
module mem_wb_pipe_stage
  import mips_pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEFAULT,
  parameter int unsigned RADDR_W = RADDR_W_DEFAULT,
  parameter int unsigned SIDE_W  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_reg_write,
  input  logic               in_mem_to_reg,
  input  logic [DATA_W-1:0]  in_mem_data,
  input  logic [DATA_W-1:0]  in_alu_result,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [SIDE_W-1:0]  in_side,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_reg_write,
  output logic               out_mem_to_reg,
  output logic [DATA_W-1:0]  out_mem_data,
  output logic [DATA_W-1:0]  out_alu_result,
  output logic [RADDR_W-1:0] out_rd,
  output logic [SIDE_W-1:0]  out_side,
  output logic [DATA_W-1:0]  wb_data,
  output logic               rf_we
`ifdef MEM_WB_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  localparam int unsigned PW = payloadWidth(DATA_W, RADDR_W, SIDE_W);

  stageState_t stateQ, stateD;
  logic [PW-1:0] inPayload, mainD, mainQ, skidQ;
  logic accept, fire, mainEn, skidEn, mainFromSkid;

  assign inPayload = {in_reg_write, in_mem_to_reg, in_mem_data, in_alu_result, in_rd, in_side};
  assign {out_reg_write, out_mem_to_reg, out_mem_data, out_alu_result, out_rd, out_side} = mainQ;

  // Handshake flags come straight from the state register: no in->out ready path.
  assign in_ready  = (stateQ != ST_TWO);
  assign out_valid = (stateQ != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign fire      = out_valid & out_ready;

  always_comb begin
    stateD       = stateQ;
    mainEn       = 1'b0;
    skidEn       = 1'b0;
    mainFromSkid = 1'b0;
    case (stateQ)
      ST_EMPTY: begin
        if (accept) begin
          stateD = ST_ONE;
          mainEn = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && fire) begin
          mainEn = 1'b1;
        end else if (accept) begin
          stateD = ST_TWO;
          skidEn = 1'b1;
        end else if (fire) begin
          stateD = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (fire) begin
          stateD       = ST_ONE;
          mainEn       = 1'b1;
          mainFromSkid = 1'b1;
        end
      end
      default: stateD = ST_EMPTY;
    endcase
    // Flush wins over everything; payload loads are suppressed too.
    if (flush) begin
      stateD = ST_EMPTY;
      mainEn = 1'b0;
      skidEn = 1'b0;
    end
  end

  assign mainD = mainFromSkid ? skidQ : inPayload;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= ST_EMPTY;
    end else begin
      stateQ <= stateD;
    end
  end

  pipe_payload_reg #(
    .WIDTH(PW)
  ) mainReg (
    .clk(clk),
    .rst(rst),
    .en (mainEn),
    .d  (mainD),
    .q  (mainQ)
  );

  pipe_payload_reg #(
    .WIDTH(PW)
  ) skidReg (
    .clk(clk),
    .rst(rst),
    .en (skidEn),
    .d  (inPayload),
    .q  (skidQ)
  );

  assign wb_data = out_mem_to_reg ? out_mem_data : out_alu_result;
  assign rf_we   = fire & out_reg_write & (out_rd != '0);

`ifdef MEM_WB_STALL_CNT_EN
  logic [31:0] stallCntQ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCntQ <= '0;
    end else if (out_valid && !out_ready && (stallCntQ != '1)) begin
      stallCntQ <= stallCntQ + 32'd1;
    end
  end

  assign stall_cnt = stallCntQ;
`endif

endmodule
